// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requester 0 is the execute stage, requester 1 the address/branch helper.
// The granted request drives the ALU. Its result is captured in a one-entry
// response buffer and returned with valid/ready handshaking.
// Optional feature: define ALU_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking. Without it, requester 0 always wins a tie.
module alu_arbiter #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WORD_SIZE-1:0] req0_a,
    input  logic [WORD_SIZE-1:0] req0_b,
    input  logic [3:0]           req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WORD_SIZE-1:0] req1_a,
    input  logic [WORD_SIZE-1:0] req1_b,
    input  logic [3:0]           req1_op,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [WORD_SIZE-1:0] rsp_result,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic [3:0]           alu_op,
    input  logic [WORD_SIZE-1:0] alu_out
);

    logic                 full_q,   full_d;
    logic                 owner_q,  owner_d;
    logic [WORD_SIZE-1:0] result_q, result_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic                 last_q,   last_d;
`endif

    logic grant1;
    logic any_valid;
    logic drain;
    logic can_accept;
    logic accept;

    // Arbitration, buffer drain/accept decision and ALU operand steering.
    // Only the owner's rsp_ready takes part in drain, so a non-owner's
    // rsp_ready never reaches any output.
    always_comb begin
        any_valid = req0_valid | req1_valid;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        grant1 = req1_valid && (!req0_valid || !last_q);
`else
        grant1 = req1_valid && !req0_valid;
`endif
        drain      = full_q && (owner_q ? rsp1_ready : rsp0_ready);
        can_accept = !full_q || drain;
        accept     = any_valid && can_accept;
        req0_ready = req0_valid && !grant1 && can_accept;
        req1_ready = grant1 && can_accept;
        alu_a      = grant1 ? req1_a  : req0_a;
        alu_b      = grant1 ? req1_b  : req0_b;
        alu_op     = grant1 ? req1_op : req0_op;
    end

    // Next state: an accept refills the buffer (even while draining),
    // a drain alone empties it and leaves the result register untouched.
    always_comb begin
        full_d   = full_q;
        owner_d  = owner_q;
        result_d = result_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        if (accept) begin
            full_d   = 1'b1;
            owner_d  = grant1;
            result_d = alu_out;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_d   = grant1;
`endif
        end else if (drain) begin
            full_d = 1'b0;
        end
    end

    // State registers; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= 1'b0;
            owner_q  <= 1'b0;
            result_q <= '0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            full_q   <= full_d;
            owner_q  <= owner_d;
            result_q <= result_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    // Response channels are decoded straight from the registered state.
    always_comb begin
        rsp0_valid = full_q && !owner_q;
        rsp1_valid = full_q && owner_q;
        rsp_result = result_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed test-plan scenarios followed by random
// traffic. A driver issues requests and pushes expected responses into a
// scoreboard. A separate monitor checks the response channels against it.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 0, req1_valid = 0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]   req0_op = 0, req1_op = 0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 0, rsp1_ready = 0;
    logic [W-1:0] rsp_result, alu_a, alu_b, alu_out;
    logic [3:0]   alu_op;

    alu_arbiter #(.WORD_SIZE(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // Reference ALU, also used as the attached ALU instance.
    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op[2:0])
            3'd0: return op[3] ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
            3'd3: return (a < b) ? 1 : 0;
            3'd4: return a ^ b;
            3'd5: return op[3] ? W'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb alu_out = alu_f(alu_op, alu_a, alu_b);

    typedef struct {
        logic         id;
        logic [W-1:0] res;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 0;

    // Behavioural model: a one-slot response holder plus last winner.
    bit   m_full = 0, m_owner = 0, m_last = 1;
    logic obs_r0, obs_r1;
    logic [3:0] obs_op;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive at negedge, check request side, model the edge.
    task automatic cycle(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [3:0] op0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [3:0] op1,
                         input logic rr0, input logic rr1);
        bit   drain, can, g, acc;
        exp_t e;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        rsp0_ready = rr0; rsp1_ready = rr1;
        #1;
        drain = m_full && (m_owner ? rr1 : rr0);
        can   = !m_full || drain;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        g = (v0 && v1) ? !m_last : v1;
`else
        g = (v0 && v1) ? 1'b0 : v1;
`endif
        acc = (v0 || v1) && can;
        obs_r0 = req0_ready; obs_r1 = req1_ready; obs_op = alu_op;
        chk("req0_ready", req0_ready, W'(acc && !g));
        chk("req1_ready", req1_ready, W'(acc && g));
        if (v0 || v1) begin
            chk("alu_a", alu_a, g ? a1 : a0);
            chk("alu_op", W'(alu_op), W'(g ? op1 : op0));
        end
        e.id  = g;
        e.res = g ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0);
        @(posedge clk);
        #1;
        if (acc) begin
            sb.push_back(e);
            m_full = 1; m_owner = g; m_last = g;
        end else if (drain) begin
            m_full = 0;
        end
    endtask

    // Monitor: response channels must match the scoreboard head every cycle.
    always @(negedge clk) begin
        #3;
        if (mon_en && !rst) begin
            if (sb.size() == 0) begin
                chk("rsp0_valid_idle", W'(rsp0_valid), 0);
                chk("rsp1_valid_idle", W'(rsp1_valid), 0);
            end else begin
                chk("rsp0_valid", W'(rsp0_valid), W'(sb[0].id == 1'b0));
                chk("rsp1_valid", W'(rsp1_valid), W'(sb[0].id == 1'b1));
                chk("rsp_result", rsp_result, sb[0].res);
                if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready))
                    void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [W-1:0] ra0, rb0, ra1, rb1;
        logic [3:0]   rop0, rop1;
        logic [3:0]   gseq, gexp;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp0_valid", W'(rsp0_valid), 0);
        chk("rst_rsp1_valid", W'(rsp1_valid), 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_req0_ready_idle", W'(req0_ready), 0);
        @(negedge clk);
        rst = 0;
        mon_en = 1;

        // ADD 5+7 from requester 0
        cycle(1, 5, 7, 4'b0000, 0, 0, 0, 0, 1, 1);
        chk("add_req0_ready", W'(obs_r0), 1);
        chk("add_rsp0_valid", W'(rsp0_valid), 1);
        chk("add_rsp1_valid", W'(rsp1_valid), 0);
        chk("add_result", rsp_result, 12);

        // SUB 3-5 from requester 1
        cycle(0, 0, 0, 0, 1, 3, 5, 4'b1000, 1, 1);
        chk("sub_alu_op", W'(obs_op), W'(4'b1000));
        chk("sub_rsp1_valid", W'(rsp1_valid), 1);
        chk("sub_result", rsp_result, 32'hFFFF_FFFE);

        // Tie for four cycles
        gseq = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, i, 1, 4'b0000, 1, i, 2, 4'b0110, 1, 1);
            chk("tie_one_ready", W'(obs_r0 ^ obs_r1), 1);
            gseq[i] = obs_r1;
        end
`ifdef ALU_ARB_ROUND_ROBIN_EN
        gexp = 4'b1010;
`else
        gexp = 4'b0000;
`endif
        chk("tie_grant_seq", W'(gseq), W'(gexp));

        // SLT -1 < 1, then hold under backpressure with req1 pending
        cycle(1, 32'hFFFF_FFFF, 1, 4'b0010, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1, 9, 4, 4'b0000, 0, 1);
            chk("bp_req0_ready", W'(obs_r0), 0);
            chk("bp_req1_ready", W'(obs_r1), 0);
            chk("bp_result_held", rsp_result, 1);
            chk("bp_rsp0_valid", W'(rsp0_valid), 1);
        end
        cycle(0, 0, 0, 0, 1, 9, 4, 4'b0000, 1, 0);
        chk("drain_accept_req1_ready", W'(obs_r1), 1);
        chk("drain_accept_rsp1_valid", W'(rsp1_valid), 1);
        chk("drain_accept_result", rsp_result, 13);

        // Hold the result, then reset asynchronously mid-cycle
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_rsp1_valid", W'(rsp1_valid), 1);
        mon_en = 0;
        #1 rst = 1;
        #1;
        chk("async_rst_rsp1_valid", W'(rsp1_valid), 0);
        chk("async_rst_rsp0_valid", W'(rsp0_valid), 0);
        chk("async_rst_result", rsp_result, 0);
        @(posedge clk);
        #2 rst = 0;
        sb.delete();
        m_full = 0; m_owner = 0; m_last = 1;
        mon_en = 1;
        cycle(1, 2, 2, 4'b0000, 1, 3, 3, 4'b0000, 1, 1);
        chk("post_rst_tie_req0", W'(obs_r0), 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            ra0 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom;
            rb0 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : $urandom;
            ra1 = $urandom; rb1 = W'($urandom_range(0, 63));
            rop0 = 4'($urandom); rop1 = 4'($urandom);
            cycle($urandom_range(0, 3) != 0, ra0, rb0, rop0,
                  $urandom_range(0, 3) != 0, ra1, rb1, rop1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        // Drain and confirm every expected response was delivered
        repeat (4) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("sb_empty", W'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational ALU between two requesters: requester 0 is the execute stage, requester 1 is the address or branch helper path. Each cycle the block grants at most one valid request and drives its operands and operation onto the ALU. It captures the ALU result in a one-entry response buffer and returns it to the granted requester with valid/ready backpressure. The block sits between the issue logic and the ALU instance.

## Interface
- WORD_SIZE, 32, operand/result width; must match the attached ALU.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid / req1_valid  input  1  request present.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  input  WORD_SIZE  operands.
- req0_op / req1_op  input  4  ALU operation; bit 3 = invert/arith flag, bits 2:0 = op select.
- rsp0_valid / rsp1_valid  output  1  result available for that requester.
- rsp0_ready / rsp1_ready  input  1  requester consumes result.
- rsp_result  output  WORD_SIZE  buffered result, shared by both response channels.
- alu_a, alu_b  output  WORD_SIZE  operands to ALU.
- alu_op  output  4  operation to ALU.
- alu_out  input  WORD_SIZE  combinational ALU result.

## Operation
- State: buffer-valid flag `full`, owner bit `owner`, result register, and last-grant bit `last` (the `last` bit exists only with the round-robin feature enabled).
- Two buffer states:
  - EMPTY: no result held.
  - FULL: result held for `owner`.
- `drain` = full && rsp[owner]_ready.
- `can_accept` = !full || drain. A result drained and a new request accepted in the same cycle is allowed, giving one result per cycle of throughput.
- Arbitration, combinational:
  - One requester valid: that requester is granted.
  - Both valid: arbitration policy decides (see Configuration).
  - reqN_ready = grantN && can_accept.
  - A ready signal is never asserted to a non-granted requester.
- ALU drive: alu_a/alu_b/alu_op carry the granted request's fields. With no request valid they carry requester 0's fields, which is don't-care.
- On accept (reqN_valid && reqN_ready):
  - Result register <= alu_out.
  - owner <= N.
  - full <= 1.
- On drain without accept: full <= 0. The result register holds its value.
- rspN_valid = full && (owner == N). rsp_result always reflects the result register.
- Requests are not buffered. A requester holds its valid and fields stable until ready; the arbiter does not require this but the result reflects the fields at the accept edge.

## Timing
- Reset values:
  - full = 0, owner = 0, last = 1, result register = 0.
  - All rsp valids = 0. rsp_result = 0.
  - Ready outputs follow the combinational equations with full = 0.
- Latency: request accepted at edge k; response valid from after edge k. Fixed 1-cycle latency.
- Throughput: one op per cycle when the owner's rsp_ready is held high.
- Backpressure: while full && !rsp[owner]_ready, both req readies = 0, and the result and owner hold.
- Reset mid-operation: a held result is discarded, rsp valids drop immediately (asynchronously), and arbitration priority restarts as at reset.
- No combinational path from rsp_ready of a non-owner to any output.

## Configuration
- Macro `ALU_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin policy.
  - On a tie, grant goes to !last.
  - `last` updates to the granted index on every accept.
  - After reset, requester 0 wins the first tie.
- Undefined: fixed priority, requester 0 always wins ties; `last` is not implemented.
- Everything else is identical in both configurations.

## Test plan
- Reset, then req0 ADD a=5, b=7 (op 4'b0000), rsp0_ready=1 -> req0_ready=1 at cycle 0; rsp0_valid=1 with rsp_result=12 next cycle; rsp1_valid=0.
- req1 SUB a=3, b=5 (op 4'b1000) -> rsp1_valid with rsp_result=0xFFFFFFFE; alu_op=4'b1000 during the accept cycle.
- Both valid for 4 cycles, rsp readies high, round-robin defined -> grants 0,1,0,1. With the macro undefined -> grants 0,0,0,0 and req1_ready stays 0.
- req0 SLT a=0xFFFFFFFF, b=1 (op 4'b0010) accepted, rsp0_ready=0 for 3 cycles -> rsp_result=1 held; req0_ready=req1_ready=0 throughout. rsp0_ready=1 plus a pending req1 -> drain and accept in the same cycle; next cycle rsp1_valid=1.
- Result held (full=1), assert rst for 1 cycle mid-cycle -> rsp valids drop to 0 asynchronously and rsp_result=0. After release, a tie is granted to requester 0.
